// File: rtl/masking_pkg.sv
// rtl/masking_pkg.sv - shared types and constants for the masked share encoder
package masking_pkg;

  localparam int          LFSR_W            = 16;
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    IDLE     = 2'd1,
    OUT      = 2'd2
  } enc_state_t;

endpackage

// File: rtl/mask_lfsr.sv
// rtl/mask_lfsr.sv - right-shifting Galois LFSR mask PRNG with 4-step unrolled advance
module mask_lfsr
  import masking_pkg::*;
#(
  parameter int W = masking_pkg::LFSR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         advance,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] TAPS     = W'(LFSR_TAPS);
  localparam logic [W-1:0] DEF_SEED = W'(LFSR_DEFAULT_SEED);

  logic [W-1:0] next4;
  logic [W-1:0] load_value;

  // Four chained Galois steps, so one accept consumes four fresh mask bits
  always_comb begin
    next4 = state;
    for (int i = 0; i < 4; i++) begin
      next4 = (next4 >> 1) ^ (next4[0] ? TAPS : '0);
    end
  end

  // An all-zero seed would lock the LFSR, so substitute the default seed
  always_comb begin
    load_value = (seed == '0) ? DEF_SEED : seed;
  end

  // Reset beats load, load beats advance; otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DEF_SEED;
    end else if (load) begin
      state <= load_value;
    end else if (advance) begin
      state <= next4;
    end
  end

endmodule

// File: rtl/masked_share_encoder.sv
// rtl/masked_share_encoder.sv - splits three plain bits into registered 2-share masked form
module masked_share_encoder
  import masking_pkg::*;
#(
  parameter int LFSR_W = masking_pkg::LFSR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_seed_valid,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_A,
  input  logic              i_B,
  input  logic              i_C,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_A0,
  output logic              o_A1,
  output logic              o_B0,
  output logic              o_B1,
  output logic              o_C0,
  output logic              o_C1,
  output logic              o_rN,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [7:0]        o_count
);

  enc_state_t        state;
  logic              accept;
  logic [LFSR_W-1:0] lfsr_state;

  // Seed loading blocks accepts; the single output slot frees only as it drains
  always_comb begin
    o_ready = 1'b0;
    if (!i_seed_valid) begin
      o_ready = (state == IDLE) || ((state == OUT) && i_ready);
    end
    accept = i_valid && o_ready;
  end

  mask_lfsr #(
    .W(LFSR_W)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (i_seed_valid),
    .seed    (i_seed),
    .advance (accept),
    .state   (lfsr_state)
  );

  // Control FSM plus registered shares; plain inputs only ever reach a register XORed with a mask
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= UNSEEDED;
      o_valid <= 1'b0;
      o_count <= 8'd0;
      o_A0    <= 1'b0;
      o_A1    <= 1'b0;
      o_B0    <= 1'b0;
      o_B1    <= 1'b0;
      o_C0    <= 1'b0;
      o_C1    <= 1'b0;
      o_rN    <= 1'b0;
    end else begin
      if (o_valid && i_ready) begin
        o_count <= o_count + 8'd1;
      end

      if (accept) begin
        o_A0 <= lfsr_state[0];
        o_A1 <= i_A ^ lfsr_state[0];
        o_B0 <= lfsr_state[1];
        o_B1 <= i_B ^ lfsr_state[1];
        o_C0 <= lfsr_state[2];
        o_C1 <= i_C ^ lfsr_state[2];
        o_rN <= lfsr_state[3];
      end

      case (state)
        UNSEEDED: begin
          if (i_seed_valid) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (accept) begin
            state   <= OUT;
            o_valid <= 1'b1;
          end
        end
        OUT: begin
          if (accept) begin
            state   <= OUT;
            o_valid <= 1'b1;
          end else if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
          end
        end
        default: begin
          state   <= UNSEEDED;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/masked_share_encoder.md
MASKED_SHARE_ENCODER -- requirements
Module: masked_share_encoder

Interface
REQ-001 SHALL have parameter LFSR_W, default 16, meaning the width of the internal mask PRNG.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 SHALL have port i_seed_valid, input, 1 bit: load-seed strobe.
REQ-005 SHALL have port i_seed, input, LFSR_W bits: PRNG seed value.
REQ-006 SHALL have ports i_A, i_B, i_C, input, 1 bit each: unmasked plain bits.
REQ-007 SHALL have port i_valid, input, 1 bit: plain-bit request.
REQ-008 SHALL have port o_ready, output, 1 bit: the encoder accepts a request this cycle.
REQ-009 SHALL have ports o_A0, o_A1, o_B0, o_B1, o_C0, o_C1, output, 1 bit each: registered 2-share outputs.
REQ-010 SHALL have port o_rN, output, 1 bit: registered fresh randomness bit for the downstream masked AND gadget.
REQ-011 SHALL have port o_valid, output, 1 bit: the share outputs are valid.
REQ-012 SHALL have port i_ready, input, 1 bit: the downstream consumer takes the shares.
REQ-013 SHALL have port o_count, output, 8 bits: number of delivered transactions, wrapping modulo 256.

Function
REQ-014 SHALL implement an FSM with states UNSEEDED, IDLE and OUT.
REQ-015 SHALL define the FSM transitions as follows:
- UNSEEDED -> IDLE on i_seed_valid.
- IDLE -> OUT on accept.
- OUT -> IDLE on i_ready without a new accept.
- OUT -> OUT on i_ready with a new accept.
REQ-016 SHALL define the PRNG as a Galois LFSR, right-shifting, with feedback mask 16'hB400; each step is: lsb = s[0]; s = s >> 1; if lsb, s ^= 16'hB400.
REQ-017 SHALL load s = i_seed on i_seed_valid in any state; an all-zero seed SHALL instead load 16'hACE1.
REQ-018 SHALL drive o_ready = 0 in UNSEEDED and in any cycle where i_seed_valid = 1 (seed load has priority over accept).
REQ-019 SHALL otherwise drive o_ready = 1 in IDLE, and in OUT only when i_ready = 1 (single-entry buffer, one transaction per cycle).
REQ-020 SHALL define accept as i_valid & o_ready.
REQ-021 SHALL, on accept, take masks from the current LFSR state: mA = s[0], mB = s[1], mC = s[2], r = s[3].
REQ-022 SHALL, on accept, register o_X0 = mX and o_X1 = X ^ mX for X in {A, B, C}, and o_rN = r.
REQ-023 SHALL, on accept, advance the LFSR by exactly 4 steps in that cycle, unrolled combinationally.
REQ-024 SHALL leave the LFSR unchanged in any cycle without accept or seed load.
REQ-025 SHALL produce the shares with 1-cycle latency: accept in cycle n gives o_valid = 1 in cycle n+1.
REQ-026 SHALL hold o_valid and all shares stable while o_valid & ~i_ready (stall); no mask is reused or redrawn during a stall.
REQ-027 SHALL increment o_count on each o_valid & i_ready, wrapping 255 -> 0.
REQ-028 SHALL NOT drop a pending OUT transaction when a seed is loaded mid-operation; the new seed affects only later accepts.
REQ-029 SHALL drive the unmasked inputs i_A, i_B, i_C only to the share XOR and SHALL NOT register them unmasked.

Reset
REQ-030 SHALL, on rst = 1 at a clock edge, set the state to UNSEEDED, s = 16'hACE1, o_valid = 0, o_count = 0, and all share outputs and o_rN = 0.
REQ-031 SHALL give rst priority over i_seed_valid and over accept in the same cycle.
REQ-032 SHALL discard any pending output on rst mid-operation.

Structure
REQ-033 SHALL place the state enum, LFSR_W, the 16'hB400 taps and the 16'hACE1 default seed in a shared package, masking_pkg.
REQ-034 SHALL implement the PRNG as one sub-module, mask_lfsr, with ports clk, rst, load, seed, advance and state; it performs the 4-step unrolled advance.
REQ-035 SHALL be directly connectable, with registered outputs, to the masked three-input AND gadget's A0..C1 and rN inputs.

Verification
REQ-036 SHALL verify: rst, then i_valid = 1 with no seed -> o_ready = 0 and o_valid stays 0.
REQ-037 SHALL verify: seed 16'h0001, then accept A = 1, B = 1, C = 0 -> next cycle A0 = 1, A1 = 0, B0 = 0, B1 = 1, C0 = 0, C1 = 0, rN = 0, and LFSR = 16'h1680.
REQ-038 SHALL verify: seed 16'h0000 -> LFSR = 16'hACE1; then accept A = B = C = 0 -> shares (1, 1), (0, 0), (0, 0) and rN = 0.
REQ-039 SHALL verify: hold i_ready = 0 for 5 cycles with o_valid = 1 -> shares stable, LFSR unchanged, o_count unchanged.
REQ-040 SHALL verify: back-to-back accepts with i_ready = 1 for 300 cycles -> o_valid = 1 every cycle after the first, o_count = 300 mod 256 = 44, and A0 ^ A1 == A for every output.
REQ-041 SHALL verify: i_seed_valid & i_valid in the same cycle -> no accept; rst during OUT -> o_valid = 0 next cycle.
